dip_sw_reg_cmd_arb: RTL and testbench
=====================================

# dip_sw_reg_cmd_arb

Parametrised switch-to-register-map command generator. It debounces `NUM_SW` front-panel switches and queues every accepted level change as a pending write request. A round-robin arbiter issues one write per request into the register-map write port and waits for the write acknowledge, with a timeout and optional retry. It sits between board GPIO and the register-map write port, in the `aclk` domain.

## Interface
- `NUM_SW`, 8 — number of switches (1..32).
- `DEBOUNCE_W`, 16 — debounce counter width; a level must be stable for 2^`DEBOUNCE_W`−1 cycles to be accepted.
- `ADDR_WIDTH`, 8 — register-map address width.
- `DATA_WIDTH`, 32 — register-map data width; `keep` is also `DATA_WIDTH` wide.
- `SW_ADDR_TABLE`, 0 — `NUM_SW*ADDR_WIDTH` vector; slice i is the target address for switch i.
- `SW_BIT_TABLE`, 0 — `NUM_SW*5` vector; slice i is the target bit index for switch i (must be < `DATA_WIDTH`).
- `TIMEOUT_CYCLES`, 1024 — number of cycles to wait for an acknowledge (≥2).
- `MAX_RETRY`, 2 — retry limit, used only with the retry feature (see Configuration).
- `INIT_PUSH`, 1 — if set, every switch becomes pending on reset exit.

Ports:
- `aclk` in 1 — the single clock.
- `areset` in 1 — synchronous, active-high reset.
- `gpio_dip_sw` in `NUM_SW` — raw asynchronous switch inputs.
- `reg_map_wr_cmd` out 1 — one-cycle write strobe.
- `reg_map_wr_addr` out `ADDR_WIDTH` — write address.
- `reg_map_wr_data` out `DATA_WIDTH` — write data.
- `reg_map_wr_keep` out `DATA_WIDTH` — per-bit write enable.
- `reg_map_wr_valid` in 1 — write acknowledge pulse.
- `reg_map_wr_ready` in 1 — register map can accept a command.
- `reg_map_wr_err` in 2 — error code, sampled with `valid`; nonzero means the write failed.
- `sw_state` out `NUM_SW` — debounced switch levels.
- `busy` out 1 — high in every state other than IDLE.
- `err_count` out 16 — saturating count of failed writes (error or timeout).
- `last_err` out 2 — most recent failure; 2'b11 means timeout.

## Operation
- **Synchroniser:** two flops, s1 then s2, per switch.
- **Debounce:** per-switch counter `ctr`.
  - `ctr` is cleared when s1≠s2.
  - Otherwise `ctr` increments until it saturates at all-ones.
  - When `ctr` is saturated and `sw_state[i]`≠s2[i]: `sw_state[i]`←s2[i] and `pending[i]`←1 on the same edge.
- **Pending bitmap:** a change on a switch that is already pending merges into the one request. Data is always taken from `sw_state` at issue time, so the latest level is written.
- **Arbiter:** round-robin. The search starts at `last_served`+1 mod `NUM_SW`. The lowest index at or after that point wins.
- **IDLE:**
  - When `|pending` and `reg_map_wr_ready` are both high, the block asserts `cmd` for one cycle.
  - It loads `addr`=`SW_ADDR_TABLE[i]`, `data`=`sw_state[i]`<<`SW_BIT_TABLE[i]`, and `keep`=1<<`SW_BIT_TABLE[i]`.
  - It clears `pending[i]`, records `last_served`=i, and moves to WAIT_ACK.
- **WAIT_ACK:**
  - The timeout counter runs from 0.
  - `valid` with `err`==0: go to IDLE.
  - `valid` with `err`≠0: record a failure and go to FAIL.
  - Counter reaches `TIMEOUT_CYCLES`−1 with no `valid`: record `last_err`=2'b11 and go to FAIL.
- **FAIL:** increment `err_count` (saturating at 16'hFFFF). Then apply the configured retry behaviour (see Configuration).
- **Same-switch change during WAIT_ACK:** re-sets `pending[i]`, which produces a further write after the current one completes.
- **`valid` in IDLE:** ignored.
- **`ready` low:** the block holds in IDLE and pending bits accumulate.
- **`addr`/`data`/`keep`:** held stable until the next issue.

## Timing
- **Reset values:**
  - `cmd`=0, `addr`/`data`/`keep`=0, `busy`=0, `err_count`=0, `last_err`=0, state=IDLE, `last_served`=`NUM_SW`−1.
  - s1, s2 and `sw_state` load `gpio_dip_sw` directly.
  - All counters are saturated.
  - `pending` is set to all-ones if `INIT_PUSH`, otherwise 0.
- **Reset mid-transaction:** the outstanding write is abandoned. No `cmd` is asserted in the cycle after reset is released.
- **Latency:** E0 is the first edge at which s1 samples a new stable level.
  - `sw_state` and `pending` update at E0+2^`DEBOUNCE_W`+1.
  - `cmd` is high after E0+2^`DEBOUNCE_W`+2, provided the block is in IDLE with `ready` high.
- **Back-to-back issue:** `valid` at edge A allows the next `cmd` at A+1, so there is a minimum of one IDLE cycle between commands.
- **`cmd` width:** never high for two consecutive cycles.
- **Glitches:** a glitch shorter than 2^`DEBOUNCE_W`−1 cycles produces no update.

## Configuration
- **`DIP_SW_CMD_RETRY_EN` defined:**
  - FAIL re-issues the same addr/data/keep when `ready` is high, up to `MAX_RETRY` times per request. Data is not re-sampled.
  - After the retries are exhausted, the request is dropped and the block returns to IDLE.
  - `err_count` counts every failed attempt.
- **Undefined:** FAIL returns to IDLE after one cycle and the request is dropped. The retry counter logic is absent.

## Test plan
- **Single change:** `NUM_SW`=4, `DEBOUNCE_W`=4, `INIT_PUSH`=0, `SW_ADDR_TABLE` slice 1=8'h20, `SW_BIT_TABLE` slice 1=0, `ready` high; switch 1 goes 0→1 → one `cmd` pulse at E0+18 with addr 8'h20, data 32'h1, keep 32'h1; ack with err 0 → `busy` low.
- **Glitch rejection:** switch 0 high for 10 cycles, then back → no `cmd`, `sw_state` unchanged.
- **Round-robin:** switches 0, 2 and 3 change on the same cycle, `last_served`=3 → commands issued in order 0, 2, 3, each after the previous ack.
- **Timeout:** no `valid` after `cmd` with `TIMEOUT_CYCLES`=16 → FAIL at 16 cycles, `last_err`=2'b11, `err_count`=1; with `DIP_SW_CMD_RETRY_EN` and `MAX_RETRY`=2 → exactly 3 `cmd` pulses with identical addr/data, then `err_count`=3.
- **`ready` low and re-pend:** `ready` held low while switch 2 toggles 0→1→0 (each level stable) → after `ready` rises, one write with data bit 0.
- **Reset:** `areset` asserted during WAIT_ACK, `INIT_PUSH`=1 → after release, `NUM_SW` writes are issued in order 0..`NUM_SW`−1 reflecting the current switch levels.

Source files
------------

// File: rtl/dip_sw_reg_cmd_arb.sv
// Debounced switch bank -> round-robin register-map writes; DIP_SW_CMD_RETRY_EN adds re-issue on failure.
// Latency: cmd rises 2^DEBOUNCE_W+2 edges after s1 first samples a new stable level.
// Backpressure: holds in IDLE while reg_map_wr_ready is low; pending changes merge per switch.
module dip_sw_reg_cmd_arb #(
  parameter int NUM_SW         = 8,
  parameter int DEBOUNCE_W     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SW*ADDR_WIDTH-1:0] SW_ADDR_TABLE = '0,
  parameter logic [NUM_SW*5-1:0]          SW_BIT_TABLE  = '0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2,
  parameter bit INIT_PUSH      = 1'b1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_SW-1:0]     gpio_dip_sw,
  output logic                  reg_map_wr_cmd,
  output logic [ADDR_WIDTH-1:0] reg_map_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_map_wr_data,
  output logic [DATA_WIDTH-1:0] reg_map_wr_keep,
  input  logic                  reg_map_wr_valid,
  input  logic                  reg_map_wr_ready,
  input  logic [1:0]            reg_map_wr_err,
  output logic [NUM_SW-1:0]     sw_state,
  output logic                  busy,
  output logic [15:0]           err_count,
  output logic [1:0]            last_err
);

  localparam int IDX_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, FAIL} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] keep;
  } wr_t;

  state_t                state, state_nxt;
  wr_t                   wr_q, wr_nxt;
  logic [NUM_SW-1:0]     s1, s2, pending, accept, clr_mask;
  logic [DEBOUNCE_W-1:0] ctr [NUM_SW];
  logic [IDX_W-1:0]      last_served, grant;
  logic                  grant_vld;
  logic [TO_W-1:0]       to_ctr;
  logic                  issue, reissue, fail_set;
  logic [1:0]            fail_code;
  logic [4:0]            sel_bit;

  // Synchroniser and per-switch debounce
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1       <= gpio_dip_sw;
      s2       <= gpio_dip_sw;
      sw_state <= gpio_dip_sw;
      for (int i = 0; i < NUM_SW; i++) ctr[i] <= '1;
    end else begin
      s1 <= gpio_dip_sw;
      s2 <= s1;
      for (int i = 0; i < NUM_SW; i++) begin
        if (s1[i] != s2[i])      ctr[i] <= '0;
        else if (ctr[i] != '1)   ctr[i] <= ctr[i] + DEBOUNCE_W'(1);
        if (accept[i])           sw_state[i] <= s2[i];
      end
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_SW; i++)
      accept[i] = (ctr[i] == '1) && (sw_state[i] != s2[i]);
  end

  // Walk from farthest to nearest so the first pending index after last_served wins
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NUM_SW; k >= 1; k--) begin
      idx = (int'(last_served) + k) % NUM_SW;
      if (pending[idx]) begin
        grant     = IDX_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_bit     = SW_BIT_TABLE[int'(grant)*5 +: 5];
    wr_nxt.addr = SW_ADDR_TABLE[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    wr_nxt.data = DATA_WIDTH'(sw_state[grant]) << sel_bit;
    wr_nxt.keep = DATA_WIDTH'(1) << sel_bit;
    clr_mask    = issue ? (NUM_SW'(1) << grant) : '0;
  end

`ifdef DIP_SW_CMD_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  logic [RETRY_W-1:0] retry_cnt;

  always_ff @(posedge aclk) begin
    if (areset)       retry_cnt <= '0;
    else if (issue)   retry_cnt <= '0;
    else if (reissue) retry_cnt <= retry_cnt + RETRY_W'(1);
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    reissue   = 1'b0;
    fail_set  = 1'b0;
    fail_code = 2'b11;
    case (state)
      IDLE: begin
        if (grant_vld && reg_map_wr_ready) begin
          issue     = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (reg_map_wr_valid) begin
          if (reg_map_wr_err == 2'b00) begin
            state_nxt = IDLE;
          end else begin
            fail_set  = 1'b1;
            fail_code = reg_map_wr_err;
            state_nxt = FAIL;
          end
        end else if (to_ctr == TO_LAST) begin
          fail_set  = 1'b1;
          state_nxt = FAIL;
        end
      end
      FAIL: begin
`ifdef DIP_SW_CMD_RETRY_EN
        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
          if (reg_map_wr_ready) begin
            reissue   = 1'b1;
            state_nxt = WAIT_ACK;
          end
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // err_count is bumped on entry to FAIL so a FAIL stalled on ready counts once
  always_ff @(posedge aclk) begin
    if (areset) begin
      reg_map_wr_cmd <= 1'b0;
      wr_q           <= '0;
      pending        <= INIT_PUSH ? '1 : '0;
      last_served    <= IDX_W'(NUM_SW - 1);
      to_ctr         <= '1;
      err_count      <= '0;
      last_err       <= '0;
    end else begin
      reg_map_wr_cmd <= issue | reissue;
      pending        <= (pending & ~clr_mask) | accept;
      if (issue) begin
        wr_q        <= wr_nxt;
        last_served <= grant;
      end
      if (issue || reissue)     to_ctr <= '0;
      else if (state == WAIT_ACK) to_ctr <= to_ctr + TO_W'(1);
      if (fail_set) begin
        last_err <= fail_code;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  assign reg_map_wr_addr = wr_q.addr;
  assign reg_map_wr_data = wr_q.data;
  assign reg_map_wr_keep = wr_q.keep;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_dip_sw_reg_cmd_arb.sv
// Directed bench for dip_sw_reg_cmd_arb: scoreboard of expected writes checked at every cmd pulse.
module tb_dip_sw_reg_cmd_arb;

  localparam int NSW = 4;
  localparam logic [NSW*8-1:0] ADDR_T = {8'h40, 8'h30, 8'h20, 8'h10};
  localparam logic [NSW*5-1:0] BIT_T  = {5'd31, 5'd7, 5'd0, 5'd3};
`ifdef DIP_SW_CMD_RETRY_EN
  localparam int TO_CMDS = 3;
  localparam int TO_ERRS = 3;
`else
  localparam int TO_CMDS = 1;
  localparam int TO_ERRS = 1;
`endif

  logic           aclk = 1'b0;
  logic           areset;
  logic [NSW-1:0] gpio_dip_sw;
  logic           reg_map_wr_cmd;
  logic [7:0]     reg_map_wr_addr;
  logic [31:0]    reg_map_wr_data, reg_map_wr_keep;
  logic           reg_map_wr_valid, reg_map_wr_ready;
  logic [1:0]     reg_map_wr_err;
  logic [NSW-1:0] sw_state;
  logic           busy;
  logic [15:0]    err_count;
  logic [1:0]     last_err;

  dip_sw_reg_cmd_arb #(
    .NUM_SW(NSW), .DEBOUNCE_W(4), .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .SW_ADDR_TABLE(ADDR_T), .SW_BIT_TABLE(BIT_T),
    .TIMEOUT_CYCLES(16), .MAX_RETRY(2), .INIT_PUSH(1'b1)
  ) dut (
    .aclk(aclk), .areset(areset), .gpio_dip_sw(gpio_dip_sw),
    .reg_map_wr_cmd(reg_map_wr_cmd), .reg_map_wr_addr(reg_map_wr_addr),
    .reg_map_wr_data(reg_map_wr_data), .reg_map_wr_keep(reg_map_wr_keep),
    .reg_map_wr_valid(reg_map_wr_valid), .reg_map_wr_ready(reg_map_wr_ready),
    .reg_map_wr_err(reg_map_wr_err), .sw_state(sw_state), .busy(busy),
    .err_count(err_count), .last_err(last_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] keep;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, passes = 0, fails = 0, ncmd = 0;
  logic prev_cmd = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int i, input logic lvl);
    exp_t e;
    logic [NSW*8-1:0] at;
    logic [NSW*5-1:0] bt;
    logic [4:0]       b;
    at     = ADDR_T;
    bt     = BIT_T;
    b      = bt[i*5 +: 5];
    e.addr = at[i*8 +: 8];
    e.data = 32'(lvl) << b;
    e.keep = 32'd1 << b;
    return e;
  endfunction

  task automatic push(input int i, input logic lvl, input int copies);
    for (int c = 0; c < copies; c++) exp_q.push_back(mk(i, lvl));
  endtask

  // Scoreboard: every cmd pulse must match the head of the expected queue
  always @(negedge aclk) begin
    if (reg_map_wr_cmd) begin
      ncmd++;
      check("cmd_width", 64'(prev_cmd), 64'd0);
      check("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(reg_map_wr_addr), 64'(mon_e.addr));
        check("wr_data", 64'(reg_map_wr_data), 64'(mon_e.data));
        check("wr_keep", 64'(reg_map_wr_keep), 64'(mon_e.keep));
      end
    end
    prev_cmd = reg_map_wr_cmd;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_cmd(input string tag, output int cyc);
    int n0;
    n0  = ncmd;
    cyc = 0;
    while (ncmd == n0 && cyc < 300) begin
      @(negedge aclk);
      #1;
      cyc++;
    end
    check(tag, 64'(ncmd > n0), 64'd1);
  endtask

  task automatic ack(input logic [1:0] e);
    reg_map_wr_valid = 1'b1;
    reg_map_wr_err   = e;
    @(posedge aclk);
    #1;
    reg_map_wr_valid = 1'b0;
    reg_map_wr_err   = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n_base;
    areset = 1'b1; gpio_dip_sw = 4'b0101;
    reg_map_wr_valid = 1'b0; reg_map_wr_ready = 1'b1; reg_map_wr_err = 2'b00;
    tick(3);

    // Reset state
    check("rst_cmd", 64'(reg_map_wr_cmd), 64'd0);
    check("rst_addr", 64'(reg_map_wr_addr), 64'd0);
    check("rst_data", 64'(reg_map_wr_data), 64'd0);
    check("rst_keep", 64'(reg_map_wr_keep), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_last_err", 64'(last_err), 64'd0);
    check("rst_sw_state", 64'(sw_state), 64'h5);

    // INIT_PUSH: every switch written in order 0..3 with its current level
    for (int i = 0; i < NSW; i++) push(i, gpio_dip_sw[i], 1);
    areset = 1'b0;
    @(negedge aclk);
    check("init_no_cmd_after_release", 64'(reg_map_wr_cmd), 64'd0);
    for (int i = 0; i < NSW; i++) begin
      wait_cmd("init_cmd", cyc);
      if (i == 1) check("back_to_back_latency", 64'(cyc), 64'd2);
      check("init_busy", 64'(busy), 64'd1);
      ack(2'b00);
    end
    tick(2);
    check("init_idle", 64'(busy), 64'd0);

    // Round-robin: switches 0, 2, 3 change together with last_served = 3
    gpio_dip_sw = 4'b1000;
    push(0, 1'b0, 1); push(2, 1'b0, 1); push(3, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      wait_cmd("rr_cmd", cyc);
      ack(2'b00);
    end
    check("rr_sw_state", 64'(sw_state), 64'h8);

    // Single change on switch 1: cmd after E0+18
    tick(3);
    gpio_dip_sw[1] = 1'b1;
    push(1, 1'b1, 1);
    wait_cmd("single_cmd", cyc);
    check("single_latency", 64'(cyc), 64'd20);
    ack(2'b00);
    check("single_busy_low", 64'(busy), 64'd0);

    // Glitch rejection: 10-cycle pulse on switch 0
    n_base = ncmd;
    gpio_dip_sw[0] = 1'b1;
    tick(10);
    gpio_dip_sw[0] = 1'b0;
    tick(40);
    check("glitch_no_cmd", 64'(ncmd - n_base), 64'd0);
    check("glitch_sw_state", 64'(sw_state), 64'hA);

    // Timeout on switch 2
    n_base = ncmd;
    gpio_dip_sw[2] = 1'b1;
    push(2, 1'b1, TO_CMDS);
    wait_cmd("to_cmd", cyc);
    repeat (15) @(negedge aclk);
    check("to_before_last_err", 64'(last_err), 64'd0);
    @(negedge aclk);
    check("to_last_err", 64'(last_err), 64'd3);
    check("to_err_count_first", 64'(err_count), 64'd1);
    check("to_busy_in_fail", 64'(busy), 64'd1);
    tick(60);
    check("to_cmd_count", 64'(ncmd - n_base), 64'(TO_CMDS));
    check("to_err_count", 64'(err_count), 64'(TO_ERRS));
    check("to_idle", 64'(busy), 64'd0);

    // Error acknowledge on switch 3
    gpio_dip_sw[3] = 1'b0;
`ifdef DIP_SW_CMD_RETRY_EN
    push(3, 1'b0, 2);
`else
    push(3, 1'b0, 1);
`endif
    wait_cmd("errack_cmd", cyc);
    ack(2'b01);
    check("errack_last_err", 64'(last_err), 64'd1);
    check("errack_err_count", 64'(err_count), 64'(TO_ERRS + 1));
    check("errack_busy", 64'(busy), 64'd1);
`ifdef DIP_SW_CMD_RETRY_EN
    wait_cmd("errack_retry_cmd", cyc);
    ack(2'b00);
`endif
    tick(2);
    check("errack_idle", 64'(busy), 64'd0);

    // valid while IDLE is ignored
    n_base = ncmd;
    reg_map_wr_valid = 1'b1; reg_map_wr_err = 2'b10;
    tick(1);
    reg_map_wr_valid = 1'b0; reg_map_wr_err = 2'b00;
    tick(2);
    check("idle_valid_last_err", 64'(last_err), 64'd1);
    check("idle_valid_err_count", 64'(err_count), 64'(TO_ERRS + 1));
    check("idle_valid_busy", 64'(busy), 64'd0);

    // ready low: switch 0 goes 0->1->0, one merged write of the final level
    reg_map_wr_ready = 1'b0;
    gpio_dip_sw[0] = 1'b1;
    tick(25);
    check("rdy_low_sw_state_hi", 64'(sw_state), 64'h7);
    gpio_dip_sw[0] = 1'b0;
    tick(25);
    check("rdy_low_sw_state_lo", 64'(sw_state), 64'h6);
    check("rdy_low_no_cmd", 64'(ncmd - n_base), 64'd0);
    reg_map_wr_ready = 1'b1;
    push(0, 1'b0, 1);
    wait_cmd("rdy_cmd", cyc);
    ack(2'b00);
    tick(40);
    check("rdy_single_write", 64'(ncmd - n_base), 64'd1);

    // Reset during WAIT_ACK, then INIT_PUSH replay of current levels
    gpio_dip_sw[1] = 1'b0;
    push(1, 1'b0, 1);
    wait_cmd("mid_cmd", cyc);
    tick(3);
    areset = 1'b1;
    tick(2);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_last_err", 64'(last_err), 64'd0);
    check("mid_rst_queue_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < NSW; i++) push(i, gpio_dip_sw[i], 1);
    areset = 1'b0;
    @(negedge aclk);
    check("mid_no_cmd_after_release", 64'(reg_map_wr_cmd), 64'd0);
    for (int i = 0; i < NSW; i++) begin
      wait_cmd("replay_cmd", cyc);
      ack(2'b00);
    end
    tick(5);
    check("final_idle", 64'(busy), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
